// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RESP,
        CLEAR,
        CDONE
    } arb_state_t;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin selector: a lone requester wins, and on a tie the
// port that did not win last time (ptr_i) is chosen.
module dmem_rr_pick (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       winner_o
);

    // Choose the winner and form a one-hot grant vector.
    always_comb begin
        winner_o = 1'b0;
        case (req_i)
            2'b01:   winner_o = 1'b0;
            2'b10:   winner_o = 1'b1;
            2'b11:   winner_o = ~ptr_i;
            default: winner_o = 1'b0;
        endcase
        gnt_o = 2'b00;
        if (|req_i) begin
            gnt_o = winner_o ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core (port 0) and the
// debug/DMA loader (port 1). One access at a time: grant, memory strobe,
// response. A clear request zeroes the memory and takes priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int          DEPTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,

    input  logic        clr_req,
    output logic        clr_done,

    output logic [31:0] mem_addr,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rd_data,
    output logic        mem_data_reset
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(WORD_BYTES * DEPTH);

    arb_state_t  state_q;
    logic        rr_q;
    mem_cmd_t    cmd_q;
    mem_cmd_t    cmd_d;

    logic        p0_rvalid_q, p1_rvalid_q;
    logic        p0_err_q, p1_err_q;
    logic [31:0] p0_rdata_q, p1_rdata_q;
    logic        clr_done_q;
    logic        mem_clr_q;

    logic [1:0]  req;
    logic [1:0]  pick_gnt;
    logic        winner;
    logic        grant_en;

    logic        in_access;
    logic [31:0] offset;
    logic        legal;
    logic [31:0] rd_word;

    assign req = {p1_req, p0_req};

    dmem_rr_pick u_pick (
        .req_i    (req),
        .ptr_i    (rr_q),
        .gnt_o    (pick_gnt),
        .winner_o (winner)
    );

    // Grants only exist in IDLE, and a pending clear blocks them.
    assign grant_en = (state_q == IDLE) && !clr_req;
    assign p0_gnt   = grant_en & pick_gnt[0];
    assign p1_gnt   = grant_en & pick_gnt[1];

    // Command presented by the winning port, captured on grant.
    always_comb begin
        cmd_d.port  = winner;
        cmd_d.we    = winner ? p1_we    : p0_we;
        cmd_d.addr  = winner ? p1_addr  : p0_addr;
        cmd_d.wdata = winner ? p1_wdata : p0_wdata;
    end

    // Legality uses the offset from the base, so addresses below the base
    // wrap to huge offsets and are rejected rather than aliased.
    assign in_access = (state_q == ACCESS);
    assign offset    = cmd_q.addr - BASE_ADDR;
    assign legal     = (cmd_q.addr[1:0] == 2'b00) && (offset < SPAN);

    assign mem_addr       = in_access ? {{(32-AW){1'b0}}, offset[2 +: AW]} : 32'h0;
    assign mem_wr_en      = in_access & legal & cmd_q.we;
    assign mem_rd_en      = in_access & legal & ~cmd_q.we;
    assign mem_wr_data    = mem_wr_en ? cmd_q.wdata : 32'h0;
    assign mem_data_reset = mem_clr_q;
    assign clr_done       = clr_done_q;

    // Writes and rejected accesses return zero data.
    assign rd_word = (legal && !cmd_q.we) ? mem_rd_data : 32'h0;

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;

    // Arbiter FSM with registered response and clear pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_q        <= 1'b1;
            cmd_q       <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_rdata_q  <= 32'h0;
            p1_rdata_q  <= 32'h0;
            clr_done_q  <= 1'b0;
            mem_clr_q   <= 1'b0;
        end else begin
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_rdata_q  <= 32'h0;
            p1_rdata_q  <= 32'h0;
            clr_done_q  <= 1'b0;
            mem_clr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        mem_clr_q <= 1'b1;
                        state_q   <= CLEAR;
                    end else if (|req) begin
                        rr_q    <= winner;
                        cmd_q   <= cmd_d;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cmd_q.port) begin
                        p1_rvalid_q <= 1'b1;
                        p1_err_q    <= ~legal;
                        p1_rdata_q  <= rd_word;
                    end else begin
                        p0_rvalid_q <= 1'b1;
                        p0_err_q    <= ~legal;
                        p0_rdata_q  <= rd_word;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                CLEAR: begin
                    clr_done_q <= 1'b1;
                    state_q    <= CDONE;
                end
                CDONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32-word memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        clr_req, clr_done;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
    logic        mem_wr_en, mem_rd_en, mem_data_reset;

    logic [31:0] mem_model [0:31];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(32), .BASE_ADDR(32'h0)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .p0_req         (p0_req),
        .p0_we          (p0_we),
        .p0_addr        (p0_addr),
        .p0_wdata       (p0_wdata),
        .p0_gnt         (p0_gnt),
        .p0_rvalid      (p0_rvalid),
        .p0_rdata       (p0_rdata),
        .p0_err         (p0_err),
        .p1_req         (p1_req),
        .p1_we          (p1_we),
        .p1_addr        (p1_addr),
        .p1_wdata       (p1_wdata),
        .p1_gnt         (p1_gnt),
        .p1_rvalid      (p1_rvalid),
        .p1_rdata       (p1_rdata),
        .p1_err         (p1_err),
        .clr_req        (clr_req),
        .clr_done       (clr_done),
        .mem_addr       (mem_addr),
        .mem_wr_en      (mem_wr_en),
        .mem_wr_data    (mem_wr_data),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_data    (mem_rd_data),
        .mem_data_reset (mem_data_reset)
    );

    // Behavioural memory: synchronous write/clear, combinational read.
    always @(posedge clk) begin
        if (mem_data_reset) begin
            for (int i = 0; i < 32; i++) mem_model[i] <= 32'h0;
        end else if (mem_wr_en) begin
            mem_model[mem_addr[4:0]] <= mem_wr_data;
        end
    end
    assign mem_rd_data = mem_model[mem_addr[4:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    // One complete transaction on port p; caller is at posedge+1 in any state.
    task automatic do_access(input string tag, input bit p, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err);
        bit got;
        if (p) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            #1;
            if (p ? p1_gnt : p0_gnt) got = 1'b1;
            else tick();
        end
        check({tag, "_gnt"}, {31'h0, got}, 32'h1);
        if (!got) begin
            drop_reqs();
            return;
        end
        check({tag, "_gnt_other"}, {31'h0, p ? p0_gnt : p1_gnt}, 32'h0);
        tick();
        drop_reqs();
        check({tag, "_wr_en"}, {31'h0, mem_wr_en}, {31'h0, we && !exp_err});
        check({tag, "_rd_en"}, {31'h0, mem_rd_en}, {31'h0, !we && !exp_err});
        if (!exp_err) check({tag, "_mem_addr"}, mem_addr, {2'b00, addr[31:2]});
        if (we && !exp_err) check({tag, "_mem_wdata"}, mem_wr_data, wdata);
        tick();
        check({tag, "_rvalid"}, {31'h0, p ? p1_rvalid : p0_rvalid}, 32'h1);
        check({tag, "_rvalid_other"}, {31'h0, p ? p0_rvalid : p1_rvalid}, 32'h0);
        check({tag, "_rdata"}, p ? p1_rdata : p0_rdata, exp_rd);
        check({tag, "_err"}, {31'h0, p ? p1_err : p0_err}, {31'h0, exp_err});
        tick();
        check({tag, "_rvalid_end"}, {31'h0, p0_rvalid | p1_rvalid}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit got;
        int waited;
        reset_n = 1'b0;
        clr_req = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
        repeat (3) tick();

        // Reset state
        check("rst_p0_gnt", {31'h0, p0_gnt}, 32'h0);
        check("rst_rvalid", {30'h0, p1_rvalid, p0_rvalid}, 32'h0);
        check("rst_p0_rdata", p0_rdata, 32'h0);
        check("rst_mem_strobes", {29'h0, mem_wr_en, mem_rd_en, mem_data_reset}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_clr_done", {31'h0, clr_done}, 32'h0);
        reset_n = 1'b1;
        tick();

        // Tie: both ports write continuously; grants alternate p0,p1,p0,p1
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h00; p0_wdata = 32'hAAAA0000;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h04; p1_wdata = 32'hBBBB1111;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            waited = 0;
            for (int n = 0; n < 8 && !got; n++) begin
                #1;
                if (p0_gnt | p1_gnt) got = 1'b1;
                else begin
                    waited++;
                    tick();
                end
            end
            check("tie_gnt_seen", {31'h0, got}, 32'h1);
            check("tie_gnt_wait", 32'(waited), 32'h0);
            check("tie_gnt_order", {30'h0, p1_gnt, p0_gnt}, (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            check("tie_wr_en", {31'h0, mem_wr_en}, 32'h1);
            tick();
            check("tie_rvalid", {30'h0, p1_rvalid, p0_rvalid}, (k % 2 == 0) ? 32'h1 : 32'h2);
            check("tie_err", {30'h0, p1_err, p0_err}, 32'h0);
            tick();
        end
        drop_reqs();
        check("tie_mem0", mem_model[0], 32'hAAAA0000);
        check("tie_mem1", mem_model[1], 32'hBBBB1111);
        tick();

        // Single read: preload word 2 then read 0x08
        do_access("pre_wr", 1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0);
        do_access("rd08", 1'b0, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0);

        // Errors: misaligned write, out-of-range read
        do_access("mis_wr", 1'b1, 1'b1, 32'h06, 32'hCAFEF00D, 32'h0, 1'b1);
        do_access("oor_rd", 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 1'b1);
        check("mis_mem1_intact", mem_model[1], 32'hBBBB1111);

        // Clear has priority over a simultaneous request
        clr_req = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h08;
        #1;
        check("clr_no_gnt", {31'h0, p0_gnt}, 32'h0);
        tick();
        check("clr_reset_pulse", {31'h0, mem_data_reset}, 32'h1);
        check("clr_gnt_blocked", {31'h0, p0_gnt}, 32'h0);
        clr_req = 1'b0;
        tick();
        check("clr_done", {31'h0, clr_done}, 32'h1);
        check("clr_reset_single", {31'h0, mem_data_reset}, 32'h0);
        check("clr_cdone_no_gnt", {31'h0, p0_gnt}, 32'h0);
        tick();
        check("clr_done_single", {31'h0, clr_done}, 32'h0);
        do_access("rd_after_clr", 1'b0, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);

        // Reset during ACCESS aborts the write
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h0C; p0_wdata = 32'h55;
        #1;
        check("rst_op_gnt", {31'h0, p0_gnt}, 32'h1);
        tick();
        check("rst_op_wr_en", {31'h0, mem_wr_en}, 32'h1);
        reset_n = 1'b0;
        p0_req = 1'b0;
        #1;
        check("rst_op_wr_dropped", {31'h0, mem_wr_en}, 32'h0);
        check("rst_op_addr", mem_addr, 32'h0);
        tick();
        reset_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            check("rst_op_no_rvalid", {30'h0, p1_rvalid, p0_rvalid}, 32'h0);
            check("rst_op_no_strobe", {29'h0, mem_wr_en, mem_rd_en, mem_data_reset}, 32'h0);
            tick();
        end
        do_access("rst_op_rd", 1'b0, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0);

        // Write on port 1, read back on port 0
        do_access("wr10", 1'b1, 1'b1, 32'h10, 32'h12345678, 32'h0, 1'b0);
        do_access("rd10", 1'b0, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
